// File: rtl/axi_sram_pkg.sv
// axi_sram_pkg: shared types and constants for the AXI SRAM slave
package axi_sram_pkg;
  localparam int ID_W = 4;
  localparam int DATA_W = 32;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR = 2'b01;
  typedef enum logic [2:0] {IDLE, RD_FETCH, RD_DATA, WR_DATA, WR_RESP} state_t;
  typedef enum logic {PRIO_RD, PRIO_WR} prio_t;
endpackage

// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if: AXI read/write channel bundle between a master and the SRAM slave
interface axi_sram_slave_if;
  import axi_sram_pkg::*;
  logic [ID_W-1:0] arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid;
  logic arready;
  logic [ID_W-1:0] rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  logic [ID_W-1:0] awid;
  logic [31:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awvalid;
  logic awready;
  logic [ID_W-1:0] wid;
  logic [DATA_W-1:0] wdata;
  logic [3:0] wstrb;
  logic wlast;
  logic wvalid;
  logic wready;
  logic [ID_W-1:0] bid;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wid, wdata, wstrb, wlast, wvalid, bready,
    input arready, rid, rdata, rresp, rlast, rvalid,
    input awready, wready, bid, bresp, bvalid
  );
  modport slave (
    input arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input awid, awaddr, awlen, awsize, awburst, awvalid,
    input wid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/sram_1p_bytewe.sv
// sram_1p_bytewe: single-port synchronous RAM, 1-cycle read latency, byte write enables
module sram_1p_bytewe #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [2**ADDR_W];
  // Byte-masked write and registered read of the addressed word
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: one-transaction-at-a-time AXI responder backed by a byte-writable SRAM
module axi_sram_slave import axi_sram_pkg::*; #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_LEN   = 15
) (
  input logic clk,
  input logic resetn,
  axi_sram_slave_if.slave bus
);
  state_t state;
  prio_t prio;
  logic [ADDR_W-1:0] idx;
  logic [7:0] len, cnt;
  logic [ID_W-1:0] id;
  logic err, wl_err;
  logic [31:0] ram_q, ar_off, aw_off;
  logic [3:0] ram_we;
  logic grant_rd, grant_wr, ar_bad, aw_bad, last;
  logic unused;
  assign ar_off = bus.araddr - BASE_ADDR;
  assign aw_off = bus.awaddr - BASE_ADDR;
  assign ar_bad = (|ar_off[31:ADDR_W+2]) || (bus.arburst != BURST_INCR) || (bus.arlen > 8'(MAX_LEN));
  assign aw_bad = (|aw_off[31:ADDR_W+2]) || (bus.awburst != BURST_INCR) || (bus.awlen > 8'(MAX_LEN));
  assign unused = ^{ar_off[1:0], aw_off[1:0], bus.arsize, bus.awsize, bus.wid};
  assign grant_rd = bus.arvalid && (!bus.awvalid || prio == PRIO_RD);
  assign grant_wr = bus.awvalid && !grant_rd;
  // readies are gated by resetn so nothing is accepted while reset is held
  assign bus.arready = resetn && (state == IDLE) && grant_rd;
  assign bus.awready = resetn && (state == IDLE) && grant_wr;
  assign bus.wready = (state == WR_DATA);
  assign bus.rvalid = (state == RD_DATA);
  assign bus.bvalid = (state == WR_RESP);
  assign last = (cnt == len);
  assign bus.rlast = (state == RD_DATA) && last;
  assign bus.rdata = ((state == RD_DATA) && !err) ? ram_q : '0;
  assign bus.rid = id;
  assign bus.bid = id;
  assign bus.rresp = err ? RESP_SLVERR : RESP_OKAY;
  assign bus.bresp = (err || wl_err) ? RESP_SLVERR : RESP_OKAY;
  assign ram_we = ((state == WR_DATA) && bus.wvalid && !err) ? bus.wstrb : 4'b0;

  sram_1p_bytewe #(.ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .addr(idx),
    .we(ram_we),
    .wdata(bus.wdata),
    .rdata(ram_q)
  );

  // Transaction sequencer: arbitration, beat counting and response tracking
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      prio <= PRIO_RD;
      id <= '0;
      idx <= '0;
      len <= '0;
      cnt <= '0;
      err <= 1'b0;
      wl_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.arready) begin
            id <= bus.arid;
            idx <= ar_off[ADDR_W+1:2];
            len <= bus.arlen;
            cnt <= '0;
            err <= ar_bad;
            state <= RD_FETCH;
          end else if (bus.awready) begin
            id <= bus.awid;
            idx <= aw_off[ADDR_W+1:2];
            len <= bus.awlen;
            cnt <= '0;
            err <= aw_bad;
            wl_err <= 1'b0;
            state <= WR_DATA;
          end
        end
        RD_FETCH: state <= RD_DATA;
        RD_DATA: begin
          if (bus.rready) begin
            if (last) begin
              state <= IDLE;
              prio <= PRIO_WR;
            end else begin
              idx <= idx + 1'b1;
              cnt <= cnt + 1'b1;
              state <= RD_FETCH;
            end
          end
        end
        WR_DATA: begin
          if (bus.wvalid) begin
            idx <= idx + 1'b1;
            cnt <= cnt + 1'b1;
            if (bus.wlast != last) wl_err <= 1'b1;
            if (last) state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bus.bready) begin
            state <= IDLE;
            prio <= PRIO_RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
